// File: rtl/pkg_config.sv
// Shared configuration for the fetch-side branch predictor: widths, BHT counter
// encoding, predictor FSM states and branch-unit op codes.
package pkg_config;

  localparam int DATA_WIDTH = 32;

  typedef logic [1:0] bht_cnt_t;

  localparam bht_cnt_t BHT_SNT = 2'b00;
  localparam bht_cnt_t BHT_WNT = 2'b01;
  localparam bht_cnt_t BHT_WT  = 2'b10;
  localparam bht_cnt_t BHT_ST  = 2'b11;

  typedef enum logic {
    BP_ACTIVE   = 1'b0,
    BP_REDIRECT = 1'b1
  } bp_state_e;

  localparam logic [2:0] BRANCH_NONE     = 3'b000;
  localparam logic [2:0] BRANCH_JAL_JALR = 3'b001;
  localparam logic [2:0] BRANCH_BEQ      = 3'b010;
  localparam logic [2:0] BRANCH_BNE      = 3'b011;
  localparam logic [2:0] BRANCH_BLT      = 3'b100;
  localparam logic [2:0] BRANCH_BGE      = 3'b101;
  localparam logic [2:0] BRANCH_BLTU     = 3'b110;
  localparam logic [2:0] BRANCH_BGEU     = 3'b111;

  function automatic logic is_cond_branch(input logic [2:0] op);
    return (op == BRANCH_BEQ)  || (op == BRANCH_BNE)  ||
           (op == BRANCH_BLT)  || (op == BRANCH_BGE)  ||
           (op == BRANCH_BLTU) || (op == BRANCH_BGEU);
  endfunction

  function automatic logic is_jump(input logic [2:0] op);
    return (op == BRANCH_JAL_JALR);
  endfunction

  // 2-bit saturating step toward the resolved outcome.
  function automatic bht_cnt_t bht_next(input bht_cnt_t cnt, input logic taken);
    bht_cnt_t nxt;
    case (cnt)
      BHT_SNT: nxt = taken ? BHT_WNT : BHT_SNT;
      BHT_WNT: nxt = taken ? BHT_WT  : BHT_SNT;
      BHT_WT:  nxt = taken ? BHT_ST  : BHT_WNT;
      default: nxt = taken ? BHT_ST  : BHT_WT;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/bht_table.sv
// Bimodal history table: array of 2-bit saturating counters with one
// combinational read port and one clocked saturating update port.
module bht_table
  import pkg_config::*;
#(
  parameter int ENTRIES = 64,
  localparam int IDX_W = $clog2(ENTRIES)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [IDX_W-1:0] rd_idx_i,
  output bht_cnt_t         rd_cnt_o,
  input  logic             upd_en_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i
);

  bht_cnt_t cnt_q [ENTRIES];

  // Read sees the pre-update value when read and update hit the same entry.
  assign rd_cnt_o = cnt_q[rd_idx_i];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < ENTRIES; i++) begin
        cnt_q[i] <= BHT_WNT;
      end
    end else if (upd_en_i) begin
      cnt_q[upd_idx_i] <= bht_next(cnt_q[upd_idx_i], upd_taken_i);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal conditional-branch predictor and one-cycle fetch redirect controller.
// Optional macro BP_STATS_EN adds saturating branch/mispredict statistics ports.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// BP_ACTIVE   | resolves train the table and may launch a redirect
// BP_REDIRECT | redirect_o driven; the resolve in EX is wrong-path, ignored
module branch_predictor
  import pkg_config::*;
#(
  parameter int BHT_ENTRIES = 64,
  localparam int IDX_W = $clog2(BHT_ENTRIES)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  fetch_valid_i,
  input  logic                  fetch_is_branch_i,
  input  logic [DATA_WIDTH-1:0] fetch_pc_i,
  input  logic [DATA_WIDTH-1:0] fetch_imm_i,
  output logic                  pred_taken_o,
  output logic [DATA_WIDTH-1:0] pred_target_o,
  input  logic                  res_valid_i,
  input  logic [DATA_WIDTH-1:0] res_pc_i,
  input  logic [2:0]            res_branch_op_i,
  input  logic                  res_taken_i,
  input  logic                  res_pred_taken_i,
  input  logic [DATA_WIDTH-1:0] res_target_i,
`ifdef BP_STATS_EN
  output logic [31:0]           stat_branches_o,
  output logic [31:0]           stat_mispredicts_o,
`endif
  output logic                  redirect_o,
  output logic [DATA_WIDTH-1:0] redirect_pc_o
);

  bp_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
  bht_cnt_t              fetch_cnt;
  logic                  res_active;
  logic                  res_cond;
  logic                  res_jump;
  logic                  res_mispredict;
  logic                  train_en;
  logic                  redirect_req;
  logic [DATA_WIDTH-1:0] correct_pc;

  bht_table #(
    .ENTRIES (BHT_ENTRIES)
  ) u_bht (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .rd_idx_i    (fetch_pc_i[IDX_W+1:2]),
    .rd_cnt_o    (fetch_cnt),
    .upd_en_i    (train_en),
    .upd_idx_i   (res_pc_i[IDX_W+1:2]),
    .upd_taken_i (res_taken_i)
  );

  assign pred_taken_o  = fetch_valid_i & fetch_is_branch_i & fetch_cnt[1];
  assign pred_target_o = fetch_pc_i + fetch_imm_i;

  assign res_active     = res_valid_i && (state_q == BP_ACTIVE);
  assign res_cond       = is_cond_branch(res_branch_op_i);
  assign res_jump       = is_jump(res_branch_op_i);
  assign res_mispredict = res_cond && (res_taken_i != res_pred_taken_i);
  assign train_en       = res_active && res_cond;
  assign redirect_req   = res_active && (res_jump || res_mispredict);

  // Jumps are never predicted, so they always go to the computed target.
  assign correct_pc = (res_jump || res_taken_i) ? res_target_i
                                                : res_pc_i + DATA_WIDTH'(4);

  always_comb begin
    state_d       = state_q;
    redirect_pc_d = redirect_pc_q;
    case (state_q)
      BP_ACTIVE: begin
        if (redirect_req) begin
          state_d       = BP_REDIRECT;
          redirect_pc_d = correct_pc;
        end
      end
      default: begin
        state_d = BP_ACTIVE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= BP_ACTIVE;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign redirect_o    = (state_q == BP_REDIRECT);
  assign redirect_pc_o = redirect_pc_q;

`ifdef BP_STATS_EN
  logic [31:0] branches_q, mispredicts_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      branches_q    <= '0;
      mispredicts_q <= '0;
    end else if (train_en) begin
      if (branches_q != '1) begin
        branches_q <= branches_q + 32'd1;
      end
      if (res_mispredict && (mispredicts_q != '1)) begin
        mispredicts_q <= mispredicts_q + 32'd1;
      end
    end
  end

  assign stat_branches_o    = branches_q;
  assign stat_mispredicts_o = mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: a reference counter model plus a
// redirect scoreboard; statistics checks are built when BP_STATS_EN is defined.
module tb_branch_predictor;
  import pkg_config::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        fetch_valid_i, fetch_is_branch_i;
  logic [31:0] fetch_pc_i, fetch_imm_i;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        res_valid_i;
  logic [31:0] res_pc_i;
  logic [2:0]  res_branch_op_i;
  logic        res_taken_i, res_pred_taken_i;
  logic [31:0] res_target_i;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
`ifdef BP_STATS_EN
  logic [31:0] stat_branches_o, stat_mispredicts_o;
`endif

  branch_predictor #(.BHT_ENTRIES(64)) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .fetch_valid_i     (fetch_valid_i),
    .fetch_is_branch_i (fetch_is_branch_i),
    .fetch_pc_i        (fetch_pc_i),
    .fetch_imm_i       (fetch_imm_i),
    .pred_taken_o      (pred_taken_o),
    .pred_target_o     (pred_target_o),
    .res_valid_i       (res_valid_i),
    .res_pc_i          (res_pc_i),
    .res_branch_op_i   (res_branch_op_i),
    .res_taken_i       (res_taken_i),
    .res_pred_taken_i  (res_pred_taken_i),
    .res_target_i      (res_target_i),
`ifdef BP_STATS_EN
    .stat_branches_o   (stat_branches_o),
    .stat_mispredicts_o(stat_mispredicts_o),
`endif
    .redirect_o        (redirect_o),
    .redirect_pc_o     (redirect_pc_o)
  );

  always #5 clk_i = ~clk_i;

  int          n_vec = 0;
  int          n_err = 0;
  logic [1:0]  m_bht [64];
  logic        m_redir;
  logic        m_dec;
  int          m_br, m_mis;
  logic [31:0] exp_q [$];

  function automatic int idx_of(input logic [31:0] pc);
    return int'(pc[7:2]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_bht[i] = 2'b01;
    m_redir = 1'b0;
    m_dec   = 1'b0;
    m_br    = 0;
    m_mis   = 0;
    exp_q.delete();
  endtask

  // Drive a resolve and update the reference model as of the coming edge.
  task automatic drive_res(input logic [2:0] op, input logic [31:0] pc, input logic tk,
                           input logic pt, input logic [31:0] tgt);
    logic act, cond, jmp;
    int   ix;
    res_valid_i      = 1'b1;
    res_branch_op_i  = op;
    res_pc_i         = pc;
    res_taken_i      = tk;
    res_pred_taken_i = pt;
    res_target_i     = tgt;
    act  = !m_redir;
    cond = (op >= BRANCH_BEQ);
    jmp  = (op == BRANCH_JAL_JALR);
    m_dec = act && (jmp || (cond && (tk != pt)));
    if (m_dec) exp_q.push_back((jmp || tk) ? tgt : pc + 32'd4);
    if (act && cond) begin
      ix = idx_of(pc);
      if (tk && m_bht[ix] != 2'b11) m_bht[ix] = m_bht[ix] + 2'b01;
      else if (!tk && m_bht[ix] != 2'b00) m_bht[ix] = m_bht[ix] - 2'b01;
      m_br++;
      if (tk != pt) m_mis++;
    end
  endtask

  task automatic finish_cycle();
    @(posedge clk_i);
    m_redir = m_dec;
    m_dec   = 1'b0;
    @(negedge clk_i);
    #1;
    res_valid_i = 1'b0;
  endtask

  task automatic step(input logic [2:0] op, input logic [31:0] pc, input logic tk,
                      input logic pt, input logic [31:0] tgt);
    drive_res(op, pc, tk, pt, tgt);
    finish_cycle();
  endtask

  task automatic idle();
    m_dec = 1'b0;
    finish_cycle();
  endtask

  task automatic fetch(input logic v, input logic b, input logic [31:0] pc, input logic [31:0] imm);
    fetch_valid_i     = v;
    fetch_is_branch_i = b;
    fetch_pc_i        = pc;
    fetch_imm_i       = imm;
    #1;
  endtask

  // Scoreboard: every redirect cycle must match the front of exp_q.
  task automatic monitor();
    logic [31:0] e;
    forever begin
      @(negedge clk_i);
      if (rst_ni && (redirect_o || exp_q.size() != 0)) begin
        n_vec++;
        if (redirect_o !== 1'b1) begin
          n_err++;
          $display("FAIL redirect_missing: redirect_o=%b required=1 pc=%h", redirect_o, exp_q[0]);
          void'(exp_q.pop_front());
        end else if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL redirect_spurious: redirect_o=1 pc=%h required no redirect", redirect_pc_o);
        end else begin
          e = exp_q.pop_front();
          if (redirect_pc_o !== e) begin
            n_err++;
            $display("FAIL redirect_pc: got %h required %h", redirect_pc_o, e);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    fetch(1'b1, 1'b1, 32'h100, 32'h20);
    #10;
    n_vec++;
    if (redirect_o !== 1'b0 || redirect_pc_o !== 32'h0) begin
      n_err++;
      $display("FAIL reset_redirect: got %b/%h required 0/00000000", redirect_o, redirect_pc_o);
    end
    n_vec++;
    if (pred_taken_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_pred: got %b required 0", pred_taken_o);
    end
    n_vec++;
    if (pred_target_o !== 32'h120) begin
      n_err++;
      $display("FAIL pred_target: got %h required 00000120", pred_target_o);
    end
    @(negedge clk_i);
    #1;
    rst_ni = 1'b1;
    fetch(1'b1, 1'b1, 32'h100, 32'hFFFF_FFF0);
    n_vec++;
    if (pred_target_o !== 32'h0F0 || pred_taken_o !== 1'b0) begin
      n_err++;
      $display("FAIL pred_target_neg: got %h/%b required 000000f0/0", pred_target_o, pred_taken_o);
    end
  endtask

  task automatic test_train();
    step(BRANCH_BEQ, 32'h100, 1'b1, 1'b0, 32'h180);
    idle();
    fetch(1'b1, 1'b1, 32'h100, 32'h0);
    n_vec++;
    if (pred_taken_o !== 1'b1) begin
      n_err++;
      $display("FAIL train_weak_taken: got %b required 1", pred_taken_o);
    end
    step(BRANCH_BEQ, 32'h100, 1'b1, 1'b1, 32'h180);
    fetch(1'b1, 1'b1, 32'h100, 32'h0);
    n_vec++;
    if (pred_taken_o !== m_bht[idx_of(32'h100)][1]) begin
      n_err++;
      $display("FAIL train_strong_taken: got %b required %b", pred_taken_o, m_bht[idx_of(32'h100)][1]);
    end
    fetch(1'b1, 1'b0, 32'h100, 32'h0);
    n_vec++;
    if (pred_taken_o !== 1'b0) begin
      n_err++;
      $display("FAIL pred_not_branch: got %b required 0", pred_taken_o);
    end
    fetch(1'b0, 1'b1, 32'h100, 32'h0);
    n_vec++;
    if (pred_taken_o !== 1'b0) begin
      n_err++;
      $display("FAIL pred_not_valid: got %b required 0", pred_taken_o);
    end
  endtask

  task automatic test_mispredict();
    step(BRANCH_BNE, 32'h200, 1'b0, 1'b1, 32'h280);
    n_vec++;
    if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h204) begin
      n_err++;
      $display("FAIL mispredict_redirect: got %b/%h required 1/00000204", redirect_o, redirect_pc_o);
    end
    idle();
    n_vec++;
    if (redirect_o !== 1'b0) begin
      n_err++;
      $display("FAIL redirect_one_cycle: got %b required 0", redirect_o);
    end
    step(BRANCH_BNE, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'h10);
    n_vec++;
    if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h0) begin
      n_err++;
      $display("FAIL redirect_wrap: got %b/%h required 1/00000000", redirect_o, redirect_pc_o);
    end
    idle();
  endtask

  task automatic test_jump();
    step(BRANCH_JAL_JALR, 32'h300, 1'b1, 1'b0, 32'h400);
    n_vec++;
    if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h400) begin
      n_err++;
      $display("FAIL jump_redirect: got %b/%h required 1/00000400", redirect_o, redirect_pc_o);
    end
    idle();
    step(BRANCH_BEQ, 32'h300, 1'b0, 1'b0, 32'h400);
    fetch(1'b1, 1'b1, 32'h300, 32'h0);
    n_vec++;
    if (pred_taken_o !== m_bht[idx_of(32'h300)][1]) begin
      n_err++;
      $display("FAIL jump_no_train: got %b required %b", pred_taken_o, m_bht[idx_of(32'h300)][1]);
    end
  endtask

  task automatic test_redirect_mask();
    step(BRANCH_BLT, 32'h510, 1'b1, 1'b0, 32'h540);
    step(BRANCH_BLT, 32'h510, 1'b1, 1'b0, 32'h540);
    n_vec++;
    if (redirect_o !== 1'b0) begin
      n_err++;
      $display("FAIL mask_second_redirect: got %b required 0", redirect_o);
    end
    step(BRANCH_BLT, 32'h510, 1'b0, 1'b0, 32'h540);
    fetch(1'b1, 1'b1, 32'h510, 32'h0);
    n_vec++;
    if (pred_taken_o !== m_bht[idx_of(32'h510)][1]) begin
      n_err++;
      $display("FAIL mask_no_train: got %b required %b", pred_taken_o, m_bht[idx_of(32'h510)][1]);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 4; i++) step(BRANCH_BGE, 32'h620, 1'b1, 1'b1, 32'h700);
    step(BRANCH_BGE, 32'h620, 1'b0, 1'b0, 32'h700);
    fetch(1'b1, 1'b1, 32'h620, 32'h0);
    n_vec++;
    if (pred_taken_o !== m_bht[idx_of(32'h620)][1]) begin
      n_err++;
      $display("FAIL saturate_high: got %b required %b", pred_taken_o, m_bht[idx_of(32'h620)][1]);
    end
    for (int i = 0; i < 2; i++) step(BRANCH_BLTU, 32'h730, 1'b0, 1'b0, 32'h800);
    for (int i = 0; i < 2; i++) step(BRANCH_BLTU, 32'h730, 1'b1, 1'b1, 32'h800);
    fetch(1'b1, 1'b1, 32'h730, 32'h0);
    n_vec++;
    if (pred_taken_o !== m_bht[idx_of(32'h730)][1]) begin
      n_err++;
      $display("FAIL saturate_low: got %b required %b", pred_taken_o, m_bht[idx_of(32'h730)][1]);
    end
  endtask

  task automatic test_same_cycle();
    logic old_pred;
    old_pred = m_bht[idx_of(32'h840)][1];
    drive_res(BRANCH_BNE, 32'h840, 1'b1, 1'b1, 32'h900);
    fetch(1'b1, 1'b1, 32'h840, 32'h0);
    n_vec++;
    if (pred_taken_o !== old_pred) begin
      n_err++;
      $display("FAIL same_cycle_old: got %b required %b", pred_taken_o, old_pred);
    end
    finish_cycle();
    fetch(1'b1, 1'b1, 32'h840, 32'h0);
    n_vec++;
    if (pred_taken_o !== m_bht[idx_of(32'h840)][1]) begin
      n_err++;
      $display("FAIL update_visible: got %b required %b", pred_taken_o, m_bht[idx_of(32'h840)][1]);
    end
  endtask

  task automatic test_invalid_op();
    step(BRANCH_NONE, 32'h950, 1'b1, 1'b0, 32'hA00);
    step(BRANCH_NONE, 32'h950, 1'b1, 1'b0, 32'hA00);
    n_vec++;
    if (redirect_o !== 1'b0) begin
      n_err++;
      $display("FAIL invalid_redirect: got %b required 0", redirect_o);
    end
    fetch(1'b1, 1'b1, 32'h950, 32'h0);
    n_vec++;
    if (pred_taken_o !== m_bht[idx_of(32'h950)][1]) begin
      n_err++;
      $display("FAIL invalid_no_train: got %b required %b", pred_taken_o, m_bht[idx_of(32'h950)][1]);
    end
  endtask

  task automatic test_async_reset();
    step(BRANCH_BEQ, 32'h960, 1'b1, 1'b0, 32'hABC);
    n_vec++;
    if (redirect_o !== 1'b1 || redirect_pc_o !== 32'hABC) begin
      n_err++;
      $display("FAIL pre_reset_redirect: got %b/%h required 1/00000abc", redirect_o, redirect_pc_o);
    end
    rst_ni = 1'b0;
    #1;
    n_vec++;
    if (redirect_o !== 1'b0 || redirect_pc_o !== 32'h0) begin
      n_err++;
      $display("FAIL async_reset_redirect: got %b/%h required 0/00000000", redirect_o, redirect_pc_o);
    end
`ifdef BP_STATS_EN
    n_vec++;
    if (stat_branches_o !== 32'h0 || stat_mispredicts_o !== 32'h0) begin
      n_err++;
      $display("FAIL async_reset_stats: got %0d/%0d required 0/0", stat_branches_o, stat_mispredicts_o);
    end
`endif
    model_reset();
    @(negedge clk_i);
    #1;
    rst_ni = 1'b1;
    fetch(1'b1, 1'b1, 32'h960, 32'h0);
    n_vec++;
    if (pred_taken_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_table: got %b required 0", pred_taken_o);
    end
  endtask

`ifdef BP_STATS_EN
  task automatic test_stats();
    logic tk, mis;
    for (int i = 0; i < 10; i++) begin
      tk  = i[0];
      mis = (i == 2) || (i == 5) || (i == 8);
      step(BRANCH_BGEU, 32'hA00, tk, tk ^ mis, 32'hB00);
      if (mis) idle();
    end
    step(BRANCH_JAL_JALR, 32'hA04, 1'b1, 1'b0, 32'hC00);
    idle();
    n_vec++;
    if (stat_branches_o !== 32'd10 || stat_branches_o !== 32'(m_br)) begin
      n_err++;
      $display("FAIL stat_branches: got %0d required 10", stat_branches_o);
    end
    n_vec++;
    if (stat_mispredicts_o !== 32'd3 || stat_mispredicts_o !== 32'(m_mis)) begin
      n_err++;
      $display("FAIL stat_mispredicts: got %0d required 3", stat_mispredicts_o);
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL timeout: simulation ran past its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    res_valid_i = 1'b0; res_pc_i = '0; res_branch_op_i = '0;
    res_taken_i = 1'b0; res_pred_taken_i = 1'b0; res_target_i = '0;
    fetch_valid_i = 1'b0; fetch_is_branch_i = 1'b0; fetch_pc_i = '0; fetch_imm_i = '0;
    rst_ni = 1'b0;
    model_reset();
    fork
      monitor();
    join_none
    test_reset();
    test_train();
    test_mispredict();
    test_jump();
    test_redirect_mask();
    test_saturate();
    test_same_cycle();
    test_invalid_op();
    test_async_reset();
`ifdef BP_STATS_EN
    test_stats();
`endif
    idle();
    idle();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d redirects outstanding, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic conditional-branch predictor and fetch redirect controller. In IF it indexes a bimodal table of 2-bit saturating counters to predict conditional branches. In EX it consumes the resolved outcome from the branch unit (its `take_o`), trains the table and, on a mispredict or jump, issues a one-cycle redirect to fetch. It is the producer and consumer on the fetch side of the branch-resolution interface.

## Interface
- `BHT_ENTRIES`, 64: number of table entries. Power of two, ≥2. `IDX_W = $clog2(BHT_ENTRIES)`.
- `DATA_WIDTH`, from `pkg_config`: address/data width.
- `clk_i` in 1: single clock, rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `fetch_valid_i` in 1: fetch PC valid this cycle.
- `fetch_is_branch_i` in 1: predecode flags a conditional branch.
- `fetch_pc_i` in `DATA_WIDTH`: fetch PC.
- `fetch_imm_i` in `DATA_WIDTH`: sign-extended B-type immediate.
- `pred_taken_o` out 1: prediction taken.
- `pred_target_o` out `DATA_WIDTH`: `fetch_pc_i + fetch_imm_i`.
- `res_valid_i` in 1: EX holds a branch or jump being resolved.
- `res_pc_i` in `DATA_WIDTH`: PC of the resolving instruction.
- `res_branch_op_i` in 3: `BRANCH_*` op code.
- `res_taken_i` in 1: actual outcome from the branch unit.
- `res_pred_taken_i` in 1: prediction carried down the pipeline with the instruction.
- `res_target_i` in `DATA_WIDTH`: computed target.
- `redirect_o` out 1: fetch must load `redirect_pc_o`; IF/ID must flush.
- `redirect_pc_o` out `DATA_WIDTH`: corrected PC.

## Operation
- Index: `pc[IDX_W+1:2]` for both fetch and resolve.
- Counter encoding: 00 strong not-taken, 01 weak not-taken, 10 weak taken, 11 strong taken.
  - Predict taken when the counter MSB = 1.
- `pred_taken_o` = `fetch_valid_i & fetch_is_branch_i & bht[idx].MSB`. It is combinational and 0 otherwise.
- Training happens when `res_valid_i` is high and the state is ACTIVE, for conditional ops only (BEQ..BGEU):
  - taken: increment, saturating at 11;
  - not taken: decrement, saturating at 00.
  - The write takes effect at the clock edge.
- `BRANCH_JAL_JALR` never trains the table. It always redirects to `res_target_i`, because fetch never predicts jumps.
- Mispredict on a conditional op when `res_taken_i != res_pred_taken_i`. The redirect PC is:
  - `res_target_i` if the branch is taken;
  - `res_pc_i + 4` otherwise (wraps modulo 2^DATA_WIDTH).
- FSM:
  - ACTIVE → REDIRECT on a mispredict or jump. `redirect_o`/`redirect_pc_o` are registered and drive in REDIRECT.
  - REDIRECT → ACTIVE unconditionally after 1 cycle.
  - In REDIRECT, `res_valid_i` is ignored: it is a wrong-path instruction, so there is no training, no redirect and no stats update.
- Simultaneous fetch read and resolve write to the same index: the read returns the old value, with no bypass.
- Invalid `res_branch_op_i`: no training, no redirect.

## Timing
- Prediction has 0-cycle latency (combinational table read).
- Table update is visible to fetch the cycle after the resolve edge.
- `redirect_o` asserts exactly 1 cycle, in the cycle after the resolving `res_valid_i`.
  - Back-to-back redirects are impossible because REDIRECT masks the next cycle.
- Reset values:
  - all counters 01;
  - FSM ACTIVE;
  - `redirect_o` 0, `redirect_pc_o` 0;
  - stats counters 0.
- Reset asserted mid-operation aborts any pending redirect immediately (asynchronous).

## Configuration
- `BP_STATS_EN` defined:
  - adds outputs `stat_branches_o` and `stat_mispredicts_o`, 32-bit each;
  - they count ACTIVE-state conditional resolves and conditional mispredicts respectively;
  - both saturate at 0xFFFF_FFFF; jumps are not counted.
- `BP_STATS_EN` undefined: the ports and counters are absent and the behaviour is otherwise identical.

## Structure
- `pkg_config`:
  - `bht_cnt_t` (logic [1:0]);
  - constants `BHT_SNT`, `BHT_WNT`, `BHT_WT`, `BHT_ST`;
  - FSM enum `bp_state_e` {BP_ACTIVE, BP_REDIRECT};
  - existing `BRANCH_*` op codes are reused.
- Sub-module `bht_table`: counter array with async reset to `BHT_WNT`, one combinational read port, one saturating update port.
- Top level holds the FSM, redirect registers and optional stats.

## Test plan
- Reset, then fetch pc 0x100 as a branch → `pred_taken_o`=0. Resolve pc 0x100 BEQ taken twice with pred 0, 1 → counter 10 then 11; fetch 0x100 → `pred_taken_o`=1.
- Resolve BNE, pc 0x200, taken=0, pred=1 → next cycle `redirect_o`=1 for 1 cycle and `redirect_pc_o`=0x204.
- Resolve JAL, target 0x400 → `redirect_o`=1 with `redirect_pc_o`=0x400; table unchanged.
- Mispredict followed by `res_valid_i` in the REDIRECT cycle (BLT taken, pred 0) → no second redirect, counter unchanged.
- Counter at 11 with a further taken resolve → stays 11; at 00 with not-taken → stays 00. A same-cycle fetch of that index returns the old value.
- `BP_STATS_EN`: 10 BGEU resolves with 3 mispredicts → `stat_branches_o`=10, `stat_mispredicts_o`=3. `rst_ni` low mid-redirect → `redirect_o`=0 immediately and stats 0.
